phase_readout: RTL and testbench

Samples the asynchronous phase outputs of an N-spin oscillator array and measures each spin's phase mismatch against spin 0 over a programmable window of clock cycles. Results are returned to the host over an AXI4-Lite read channel. The block sits beside the coupled-cell array and is the read path of the Ising core: the host writes weights into the cells, then reads phases and spin states back through this block.

---
 rtl/phase_readout.sv | 148 ++++++++++++++
 tb/tb_phase_readout.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/phase_readout.sv
// rtl/phase_readout.sv - phase mismatch counters with an AXI4-Lite read port
//
// Purpose:
//   Synchronizes the asynchronous oscillator phase outputs. It then counts,
//   for each spin 1..N-1, the cycles of a programmable window in which that
//   spin differs from spin 0. Status and counts are read over AXI4-Lite.
//
// Ports:
//   clk            system / AXI clock
//   axi_rst        asynchronous active-high reset
//   phase[N]       raw oscillator outputs, asynchronous to clk
//   sample_start   one-cycle pulse that starts a window
//   sample_cycles  window length in cycles, captured at start (0 = ignored)
//   busy / done    window running / window complete
//   araddr, arvalid, arready                AXI read address channel
//   rdata, rresp, rvalid, rready            AXI read data channel
//
// Register map (word index = araddr[ADDR_W-1:2]):
//   0      status {ph_s (up to 30 bits), done, busy}
//   1      reserved, reads 0
//   i+1    cnt[i] for i = 1..N-1
//   >N     SLVERR, data 0
module phase_readout #(
   parameter int N      = 8,
   parameter int CNT_W  = 16,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              axi_rst,
   input  logic [N-1:0]      phase,
   input  logic              sample_start,
   input  logic [31:0]       sample_cycles,
   output logic              busy,
   output logic              done,
   input  logic [ADDR_W-1:0] araddr,
   input  logic              arvalid,
   output logic              arready,
   output logic [31:0]       rdata,
   output logic [1:0]        rresp,
   output logic              rvalid,
   input  logic              rready
);

   localparam int NS = (N > 30) ? 30 : N;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic             load_win;
   logic [31:0]      remaining;
   logic [N-1:0]     ph_m, ph_s;
   logic [CNT_W-1:0] cnt [1:N-1];

   logic [31:0]      rd_word;
   logic [1:0]       rd_resp;
   logic [31:0]      idx;
   logic             unused_addr_bits;

   // Two-flop synchronizer; only ph_s is used past this point.
   always_ff @(posedge clk or posedge axi_rst) begin
      if (axi_rst) begin
         ph_m <= '0;
         ph_s <= '0;
      end else begin
         ph_m <= phase;
         ph_s <= ph_m;
      end
   end

   always_ff @(posedge clk or posedge axi_rst) begin
      if (axi_rst) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      load_win = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (sample_start && (sample_cycles != 32'd0)) begin
               state_d  = RUN;
               load_win = 1'b1;
            end
         end
         RUN: begin
            // The sample taken while remaining==1 is the last one.
            if (remaining == 32'd1) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

   always_ff @(posedge clk or posedge axi_rst) begin
      if (axi_rst) begin
         remaining <= '0;
         for (int i = 1; i < N; i++) cnt[i] <= '0;
      end else if (load_win) begin
         remaining <= sample_cycles;
         for (int i = 1; i < N; i++) cnt[i] <= '0;
      end else if (state_q == RUN) begin
         remaining <= remaining - 32'd1;
         for (int i = 1; i < N; i++) begin
            if ((ph_s[i] ^ ph_s[0]) && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end

   // Read decode; the word is captured into rdata when the address is accepted.
   assign idx              = 32'(araddr[ADDR_W-1:2]);
   assign unused_addr_bits = ^araddr[1:0];

   always_comb begin
      rd_word = '0;
      rd_resp = 2'b00;
      if (idx == 32'd0) begin
         rd_word[0] = busy;
         rd_word[1] = done;
         for (int j = 0; j < NS; j++) rd_word[j+2] = ph_s[j];
      end else if (idx > 32'(N)) begin
         rd_resp = 2'b10;
      end else begin
         for (int i = 1; i < N; i++) begin
            if (idx == 32'(i + 1)) rd_word = 32'(cnt[i]);
         end
      end
   end

   assign arready = !rvalid;

   always_ff @(posedge clk or posedge axi_rst) begin
      if (axi_rst) begin
         rvalid <= 1'b0;
         rdata  <= '0;
         rresp  <= 2'b00;
      end else if (arvalid && arready) begin
         rvalid <= 1'b1;
         rdata  <= rd_word;
         rresp  <= rd_resp;
      end else if (rvalid && rready) begin
         rvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_phase_readout.sv
// tb/tb_phase_readout.sv - scoreboard testbench for phase_readout
module tb_phase_readout;

   localparam int N = 8;

   logic        clk = 1'b0;
   logic        axi_rst = 1'b1;
   logic [N-1:0] phase = '0;
   logic        sample_start = 1'b0;
   logic [31:0] sample_cycles = '0;
   logic [7:0]  araddr = '0;
   logic        arvalid = 1'b0;
   logic        rready = 1'b0;

   logic        busy, done, arready, rvalid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        busy_s, done_s, arready_s, rvalid_s;
   logic [31:0] rdata_s;
   logic [1:0]  rresp_s;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      bit          sat;
      string       tag;
   } exp_t;
   exp_t sb[$];

   phase_readout #(.N(N), .CNT_W(16), .ADDR_W(8)) dut (
      .clk(clk), .axi_rst(axi_rst), .phase(phase),
      .sample_start(sample_start), .sample_cycles(sample_cycles),
      .busy(busy), .done(done),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
   );

   // Narrow-counter copy for saturation; shares all inputs with dut.
   phase_readout #(.N(N), .CNT_W(4), .ADDR_W(8)) dut_sat (
      .clk(clk), .axi_rst(axi_rst), .phase(phase),
      .sample_start(sample_start), .sample_cycles(sample_cycles),
      .busy(busy_s), .done(done_s),
      .araddr(araddr), .arvalid(arvalid), .arready(arready_s),
      .rdata(rdata_s), .rresp(rresp_s), .rvalid(rvalid_s), .rready(rready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic axi_read(input string tag, input int idx, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input bit sat);
      exp_t e;
      int   n;
      e.data = exp_data; e.resp = exp_resp; e.sat = sat; e.tag = tag;
      sb.push_back(e);
      araddr  = 8'(idx << 2);
      arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 10) begin
         tick();
         n++;
      end
      e = sb.pop_front();
      if (!rvalid) begin
         check_val({e.tag, "_timeout"}, 32'(rvalid), 32'd1);
      end else begin
         check_val({e.tag, "_data"}, e.sat ? rdata_s : rdata, e.data);
         check_val({e.tag, "_resp"}, 32'(e.sat ? rresp_s : rresp), 32'(e.resp));
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
   endtask

   task automatic start_window(input logic [31:0] cyc);
      sample_cycles = cyc;
      sample_start  = 1'b1;
      tick();
      sample_start  = 1'b0;
   endtask

   // Counts cycles with busy high, starting just after the start edge.
   task automatic count_busy(input int restart_at, output int n);
      n = 0;
      while (busy && n < 200) begin
         n++;
         if (n == restart_at) begin
            sample_cycles = 32'd5;
            sample_start  = 1'b1;
         end else begin
            sample_start  = 1'b0;
         end
         tick();
      end
      sample_start = 1'b0;
   endtask

   initial begin
      int          n;
      logic [31:0] held;

      // Reset
      repeat (3) tick();
      axi_rst = 1'b0;
      check_val("rst_arready", 32'(arready), 32'd1);
      check_val("rst_rvalid", 32'(rvalid), 32'd0);
      check_val("rst_rdata", rdata, 32'd0);
      check_val("rst_rresp", 32'(rresp), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      axi_read("rst_idx2", 2, 32'd0, 2'b00, 0);

      // Basic window
      phase = 8'b0000_0010;
      repeat (4) tick();
      start_window(32'd10);
      count_busy(-1, n);
      check_val("basic_busy_len", 32'(n), 32'd10);
      check_val("basic_done", 32'(done), 32'd1);
      axi_read("basic_cnt1", 2, 32'd10, 2'b00, 0);
      axi_read("basic_cnt2", 3, 32'd0, 2'b00, 0);
      axi_read("basic_rsvd", 1, 32'd0, 2'b00, 0);
      axi_read("basic_status", 0, 32'h0000_000A, 2'b00, 0);

      // Saturation and ignored restart
      start_window(32'd40);
      count_busy(5, n);
      check_val("sat_busy_len", 32'(n), 32'd40);
      axi_read("sat_cnt1", 2, 32'd15, 2'b00, 1);
      axi_read("wide_cnt1", 2, 32'd40, 2'b00, 0);

      // Decode error
      axi_read("decode_err", N + 1, 32'd0, 2'b10, 0);
      axi_read("last_cnt", N, 32'd0, 2'b00, 0);

      // Back-pressure
      araddr  = 8'(2 << 2);
      arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      held = rdata;
      check_val("bp_data", held, 32'd40);
      for (int k = 0; k < 5; k++) begin
         check_val("bp_rvalid", 32'(rvalid), 32'd1);
         check_val("bp_arready", 32'(arready), 32'd0);
         check_val("bp_stable", rdata, held);
         tick();
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      check_val("bp_arready_back", 32'(arready), 32'd1);
      check_val("bp_rvalid_drop", 32'(rvalid), 32'd0);

      // Toggling reference: period-8 square on phase[0], phase[1] inverted
      phase = '0;
      for (int k = 0; k < 100; k++) begin
         if (k % 4 == 0) phase[0] = ~phase[0];
         phase[1] = ~phase[0];
         phase[2] = 1'b0;
         if (k == 16) begin
            sample_cycles = 32'd64;
            sample_start  = 1'b1;
         end else begin
            sample_start  = 1'b0;
         end
         tick();
      end
      check_val("tog_done", 32'(done), 32'd1);
      axi_read("tog_cnt1", 2, 32'd64, 2'b00, 0);
      axi_read("tog_cnt2", 3, 32'd32, 2'b00, 0);
      axi_read("tog_sat_cnt2", 3, 32'd15, 2'b00, 1);

      // Reset mid-window
      phase = 8'b0000_0010;
      repeat (4) tick();
      start_window(32'd20);
      repeat (4) tick();
      axi_rst = 1'b1;
      #1;
      check_val("midrst_busy", 32'(busy), 32'd0);
      tick();
      axi_rst = 1'b0;
      axi_read("midrst_cnt1", 2, 32'd0, 2'b00, 0);
      repeat (4) tick();
      start_window(32'd3);
      count_busy(-1, n);
      check_val("midrst_busy_len", 32'(n), 32'd3);
      check_val("midrst_done", 32'(done), 32'd1);
      axi_read("midrst_new_cnt1", 2, 32'd3, 2'b00, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
